// File: rtl/hls_ctrl_launcher_if.sv
// hls_ctrl_launcher_if: AXI-lite control channel between the launcher (master) and an HLS kernel's s_axi_control (slave).
interface hls_ctrl_launcher_if;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/hls_ctrl_launcher.sv
// hls_ctrl_launcher: loads 64-bit kernel args over AXI-lite, sets ap_start, waits for ap_done, reports status.
// Define HLS_CTRL_LAUNCHER_IRQ_EN to wait on interrupt_i (GIE/IER enable, ISR clear) instead of polling CTRL.
module hls_ctrl_launcher #(
  parameter int          NUM_ARGS       = 3,
  parameter logic [31:0] ARG_BASE       = 32'h10,
  parameter logic [31:0] ARG_STRIDE     = 32'h0C,
  parameter int          POLL_GAP       = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    launch_i,
  input  logic [NUM_ARGS*64-1:0]  args_i,
  input  logic                    interrupt_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [1:0]              err_code_o,
  hls_ctrl_launcher_if.master     m_ctrl_axilite
);
  localparam logic [2:0] S_IDLE = 3'd0, S_WR_ADDR = 3'd1, S_WR_RESP = 3'd2, S_RD_ADDR = 3'd3,
                         S_RD_RESP = 3'd4, S_POLL_WAIT = 3'd5, S_IRQ_WAIT = 3'd6, S_FINISH = 3'd7;
`ifdef HLS_CTRL_LAUNCHER_IRQ_EN
  localparam int         NPRE   = 2;
  localparam logic [2:0] S_WAIT = S_IRQ_WAIT;
`else
  localparam int         NPRE   = 0;
  localparam logic [2:0] S_WAIT = S_RD_ADDR;
`endif
  localparam logic [7:0] ARG_WORDS = 8'(2*NUM_ARGS);
  localparam logic [7:0] CTRL_IDX  = 8'(2*NUM_ARGS + NPRE);
  logic [2:0]            r_state;
  logic [NUM_ARGS*64-1:0] r_args;
  logic [7:0]            r_widx, w_nidx;
  logic                  r_awvalid, r_wvalid;
  logic [31:0]           r_awaddr, r_wdata, r_tmo, r_gap, w_naddr, w_ndata;
  logic [1:0]            r_code;
  logic                  w_aw_hs, w_w_hs, w_tmo, w_load, w_unused;
  // Write list index k: arg words, then GIE/IER (irq build), CTRL, then ISR one past CTRL.
  function automatic logic [63:0] item(input logic [NUM_ARGS*64-1:0] a, input logic [7:0] k);
    if (k < ARG_WORDS)
      return {ARG_BASE + 32'(k >> 1) * ARG_STRIDE + 32'({k[0], 2'b00}), a[32*int'(k) +: 32]};
    if (k == CTRL_IDX) return {32'h0, 32'h1};
    if (k == CTRL_IDX + 8'd1) return {32'hC, 32'h1};
    return {(k == ARG_WORDS) ? 32'h4 : 32'h8, 32'h1};
  endfunction
  assign w_aw_hs  = r_awvalid && m_ctrl_axilite.awready;
  assign w_w_hs   = r_wvalid && m_ctrl_axilite.wready;
  assign w_tmo    = TIMEOUT_CYCLES != 32'd0 && r_tmo >= TIMEOUT_CYCLES;
  assign w_unused = ^{interrupt_i, m_ctrl_axilite.rdata[31:2], m_ctrl_axilite.rdata[0]};
  always_comb begin
    w_nidx = (r_state == S_IDLE) ? 8'd0 : r_widx + 8'd1;
    {w_naddr, w_ndata} = item((r_state == S_IDLE) ? args_i : r_args, w_nidx);
    w_load = (r_state == S_IDLE && launch_i) ||
             (r_state == S_WR_RESP && m_ctrl_axilite.bvalid && m_ctrl_axilite.bresp == 2'b00 && r_widx < CTRL_IDX)
`ifdef HLS_CTRL_LAUNCHER_IRQ_EN
             || (r_state == S_IRQ_WAIT && interrupt_i)
`endif
             ;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_args    <= '0;
      r_widx    <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_tmo     <= '0;
      r_gap     <= '0;
      r_code    <= '0;
    end else begin
      r_tmo <= r_tmo + 32'(~&r_tmo);
      case (r_state)
        S_IDLE: if (launch_i) begin
          r_args <= args_i;
          r_code <= 2'd0;
        end
        S_WR_ADDR: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs) r_wvalid <= 1'b0;
          if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) r_state <= S_WR_RESP;
        end
        S_WR_RESP: if (m_ctrl_axilite.bvalid) begin
          r_code  <= (m_ctrl_axilite.bresp != 2'b00) ? 2'd1 : r_code;
          r_state <= (m_ctrl_axilite.bresp != 2'b00 || r_widx != CTRL_IDX) ? S_FINISH : S_WAIT;
          if (r_widx == CTRL_IDX) r_tmo <= '0;
        end
        S_RD_ADDR: if (m_ctrl_axilite.arready) r_state <= S_RD_RESP;
        S_RD_RESP: if (m_ctrl_axilite.rvalid) begin
          r_code  <= (m_ctrl_axilite.rresp != 2'b00) ? 2'd2 : r_code;
          r_state <= (m_ctrl_axilite.rresp != 2'b00 || m_ctrl_axilite.rdata[1]) ? S_FINISH : S_POLL_WAIT;
          r_gap   <= '0;
        end
        S_POLL_WAIT: begin
          r_gap   <= r_gap + 32'd1;
          r_code  <= w_tmo ? 2'd3 : r_code;
          r_state <= w_tmo ? S_FINISH : (r_gap + 32'd1 >= 32'(POLL_GAP)) ? S_RD_ADDR : S_POLL_WAIT;
        end
        S_IRQ_WAIT: if (w_tmo && !w_load) begin
          r_code  <= 2'd3;
          r_state <= S_FINISH;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_load) begin
        r_state   <= S_WR_ADDR;
        r_widx    <= w_nidx;
        r_awaddr  <= w_naddr;
        r_wdata   <= w_ndata;
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
      end
    end
  assign m_ctrl_axilite.awvalid = r_awvalid;
  assign m_ctrl_axilite.awaddr  = r_awaddr;
  assign m_ctrl_axilite.awprot  = 3'd0;
  assign m_ctrl_axilite.wvalid  = r_wvalid;
  assign m_ctrl_axilite.wdata   = r_wdata;
  assign m_ctrl_axilite.wstrb   = 4'hF;
  assign m_ctrl_axilite.bready  = r_state == S_WR_RESP;
  assign m_ctrl_axilite.arvalid = r_state == S_RD_ADDR;
  assign m_ctrl_axilite.araddr  = 32'h0;
  assign m_ctrl_axilite.arprot  = 3'd0;
  assign m_ctrl_axilite.rready  = r_state == S_RD_RESP;
  assign busy_o     = r_state != S_IDLE;
  assign done_o     = r_state == S_FINISH;
  assign err_o      = done_o && r_code != 2'd0;
  assign err_code_o = r_code;
endmodule

// File: tb/tb_hls_ctrl_launcher.sv
// tb_hls_ctrl_launcher: randomized bench with an AXI-lite kernel model and a write-list reference model.
module tb_hls_ctrl_launcher;
  localparam int NA  = 3;
  localparam int TMO = 100;
  localparam int GAP = 16;
`ifdef HLS_CTRL_LAUNCHER_IRQ_EN
  localparam int NPRE = 2, NISR = 1, IRQ = 1;
`else
  localparam int NPRE = 0, NISR = 0, IRQ = 0;
`endif
  localparam int NW = 2*NA + 1 + NPRE + NISR;
  logic clk_i = 1'b0, rst_i = 1'b1, launch_i = 1'b0, interrupt_i = 1'b0;
  logic [NA*64-1:0] args_i = '0;
  logic busy_o, done_o, err_o;
  logic [1:0] err_code_o;
  hls_ctrl_launcher_if bus();
  hls_ctrl_launcher #(.NUM_ARGS(NA), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .launch_i(launch_i), .args_i(args_i), .interrupt_i(interrupt_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o), .m_ctrl_axilite(bus)
  );
  always #5 clk_i = ~clk_i;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;
  int max_d = 0, done_after = 3, err_at = 0, irq_delay = 50;
  int n_rd = 0, last_hs = 0, ctrl_b = 0, done_cyc = 0;
  logic [63:0] wq[$], exp_q[$];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Kernel control slave: independent random AW/W ready delays, B one step after both, status reads.
  initial begin
    bit aw_p, w_p, b_p, ar_p, r_p, aw_got, w_got, aw_seen, w_seen;
    logic [31:0] aw_cap, w_cap;
    int aw_d, w_d, irq_cnt;
    {aw_p, w_p, b_p, ar_p, r_p, aw_got, w_got, aw_seen, w_seen} = '0;
    aw_d = 0; w_d = 0; irq_cnt = -1; aw_cap = 0; w_cap = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_i) begin
        {aw_p, w_p, b_p, ar_p, r_p, aw_got, w_got, aw_seen, w_seen} = '0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.arready = 0; bus.rvalid = 0;
        irq_cnt = -1; interrupt_i = 0;
      end else begin
        if (r_p) begin r_p = 0; bus.rvalid = 0; end
        if (ar_p) begin
          ar_p = 0; bus.arready = 0; n_rd++; bus.rvalid = 1; bus.rresp = 0;
          bus.rdata = (n_rd >= done_after) ? 32'h6 : 32'h1;
        end
        if (b_p) begin b_p = 0; bus.bvalid = 0; end
        if (aw_p) begin aw_p = 0; bus.awready = 0; aw_got = 1; end
        if (w_p) begin w_p = 0; bus.wready = 0; w_got = 1; end
        if (aw_got && w_got) begin
          wq.push_back({aw_cap, w_cap});
          aw_got = 0; w_got = 0; bus.bvalid = 1;
          bus.bresp = (wq.size() == err_at) ? 2'b10 : 2'b00;
          if (aw_cap == 32'h0) irq_cnt = irq_delay;
          if (aw_cap == 32'hC) interrupt_i = 0;
        end
        if (bus.bvalid && bus.bready) begin
          b_p = 1; last_hs = cyc + 1;
          if (wq[wq.size()-1][63:32] == 32'h0) ctrl_b = cyc + 1;
        end
        if (bus.rvalid && bus.rready) begin r_p = 1; last_hs = cyc + 1; end
        if (bus.arvalid && !bus.arready && !ar_p) begin
          chk("araddr", bus.araddr, 0);
          bus.arready = 1; ar_p = 1;
        end
        if (bus.awvalid && !aw_p && !aw_got) begin
          if (!aw_seen) begin aw_seen = 1; aw_cap = bus.awaddr; end
          if (aw_d == 0) begin
            chk("aw_stable", bus.awaddr, aw_cap);
            bus.awready = 1; aw_p = 1; aw_seen = 0; aw_d = $urandom_range(0, max_d);
          end else aw_d--;
        end
        if (bus.wvalid && !w_p && !w_got) begin
          if (!w_seen) begin w_seen = 1; w_cap = bus.wdata; end
          if (w_d == 0) begin
            chk("w_stable", {bus.wstrb, bus.wdata}, {4'hF, w_cap});
            bus.wready = 1; w_p = 1; w_seen = 0; w_d = $urandom_range(0, max_d);
          end else w_d--;
        end
        if (irq_cnt > 0) irq_cnt--;
        else if (irq_cnt == 0) begin interrupt_i = 1; irq_cnt = -1; end
      end
    end
  end
  // Reference write list built straight from the register map.
  task automatic model(input logic [NA*64-1:0] a);
    logic [63:0] v;
    exp_q.delete();
    for (int i = 0; i < NA; i++) begin
      v = a[64*i +: 64];
      exp_q.push_back({32'h10 + 32'(i) * 32'h0C, v[31:0]});
      exp_q.push_back({32'h14 + 32'(i) * 32'h0C, v[63:32]});
    end
    if (IRQ == 1) begin exp_q.push_back({32'h4, 32'h1}); exp_q.push_back({32'h8, 32'h1}); end
    exp_q.push_back({32'h0, 32'h1});
    if (IRQ == 1) exp_q.push_back({32'hC, 32'h1});
  endtask
  task automatic run(input string tag, input logic [NA*64-1:0] a, input logic [1:0] code, input int n, input int nrd);
    int t;
    wq.delete(); n_rd = 0; model(a);
    args_i = a; launch_i = 1;
    @(posedge clk_i); #1;
    launch_i = 0;
    chk({tag, ":busy_rise"}, {62'd0, busy_o, done_o}, 2'b10);
    chk({tag, ":first_wr"}, {bus.awvalid, bus.wvalid, bus.awaddr, bus.wdata}, {2'b11, exp_q[0]});
    t = 0;
    while (!done_o && t < 3000) begin
      launch_i = (t == 5);
      @(posedge clk_i); #1;
      t++;
    end
    launch_i = 0; done_cyc = cyc;
    chk({tag, ":done"}, done_o, 1);
    chk({tag, ":err"}, {err_o, err_code_o}, {code != 2'd0, code});
    chk({tag, ":n_writes"}, wq.size(), n);
    for (int i = 0; i < wq.size() && i < n; i++) chk({tag, ":write"}, wq[i], exp_q[i]);
    if (nrd >= 0) chk({tag, ":n_reads"}, n_rd, nrd);
    if (code != 2'd3) chk({tag, ":done_lat"}, done_cyc, last_hs);
    @(posedge clk_i); #1;
    chk({tag, ":after"}, {done_o, busy_o, err_o, err_code_o}, {3'b000, code});
  endtask
  initial begin
    logic [NA*64-1:0] a;
    int t;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_status", {busy_o, done_o, err_o, err_code_o}, 0);
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    chk("rst_addr_data", {bus.awaddr, bus.wdata}, 0);
    rst_i = 0;
    @(posedge clk_i); #1;
    run("plan", {64'h3000, 64'h2000, 64'h1_0000_1000}, 2'd0, NW, IRQ == 1 ? 0 : 3);
    max_d = 5;
    for (int i = 0; i < 3; i++) begin
      done_after = $urandom_range(1, 4);
      a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run("rand", a, 2'd0, NW, IRQ == 1 ? 0 : done_after);
    end
    err_at = 3;
    a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run("bresp", a, 2'd1, 3, 0);
    err_at = 0; done_after = 1000000; irq_delay = 1000000;
    run("tmo", a, 2'd3, NW - NISR, -1);
    chk("tmo_window", (done_cyc - ctrl_b > TMO) && (done_cyc - ctrl_b <= TMO + GAP + 8), 1);
    done_after = 2; irq_delay = 50; max_d = 0;
    args_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    launch_i = 1;
    @(posedge clk_i); #1;
    launch_i = 0; t = 0;
    while (!bus.bready && t < 50) begin @(posedge clk_i); #1; t++; end
    chk("rst_mid_wr_resp", bus.bready, 1);
    #2 rst_i = 1;
    #1;
    chk("rst_async", {busy_o, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    @(posedge clk_i); #1;
    rst_i = 0;
    @(posedge clk_i); #1;
    a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run("post_rst", a, 2'd0, NW, IRQ == 1 ? 0 : 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hls_ctrl_launcher.md
# hls_ctrl_launcher

AXI-lite master that drives the `s_axi_control` slave port of a Vitis-HLS kernel wrapper such as `krnl_conv_opt3`. On a single launch pulse it:
- writes the kernel's 64-bit pointer arguments,
- sets `ap_start`,
- waits for `ap_done`, by polling or by interrupt,
- reports completion status to local control logic.

It sits between a local sequencer or CSR block and one HLS kernel's control slave, and replaces software-driven kernel launch.

## Interface
- `NUM_ARGS`, default 3: number of 64-bit kernel arguments.
- `ARG_BASE`, default 32'h10: offset of argument 0 low word.
- `ARG_STRIDE`, default 32'h0C: offset step between consecutive arguments.
- `POLL_GAP`, default 16: idle cycles between status reads, polling mode.
- `TIMEOUT_CYCLES`, default 0: cycles allowed from start write to done; 0 disables the timeout.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `launch_i`  in  1  launch request pulse; ignored while `busy_o` is high.
- `args_i`  in  NUM_ARGS*64  argument values; arg i occupies bits [64i+63:64i]; sampled on an accepted launch.
- `interrupt_i`  in  1  kernel interrupt line.
- `busy_o`  out  1  sequence in progress.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  asserted together with `done_o` when the sequence failed.
- `err_code_o`  out  2  0 ok, 1 BRESP!=OKAY, 2 RRESP!=OKAY, 3 timeout; held until next launch.
- AXI-lite master, all `m_ctrl_axilite_*`:
  - `awvalid`/`awready`, `awaddr[31:0]`, `awprot[2:0]`=0
  - `wvalid`/`wready`, `wdata[31:0]`, `wstrb[3:0]`=4'hF
  - `bvalid`/`bready`, `bresp[1:0]`
  - `arvalid`/`arready`, `araddr[31:0]`, `arprot[2:0]`=0
  - `rvalid`/`rready`, `rdata[31:0]`, `rresp[1:0]`

## Operation
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, POLL_WAIT, IRQ_WAIT, FINISH.
- Launch in IDLE: latch `args_i`, clear `err_code_o`, set `busy_o`, go to WR_ADDR.
- Write list, in order:
  1. For i = 0..NUM_ARGS-1: write arg[i][31:0] to ARG_BASE+i*ARG_STRIDE, then arg[i][63:32] to that address +4.
  2. IRQ build only: GIE (0x04) ← 1, then IER (0x08) ← 1.
  3. CTRL (0x00) ← 1, which sets `ap_start`.
- WR_ADDR:
  - AW and W channels are asserted together.
  - Each channel's valid drops independently after its own handshake.
  - Go to WR_RESP once both channels have completed.
- WR_RESP:
  - `bready` is high.
  - On `bvalid`: if `bresp`!=0, set code 1 and go to FINISH; otherwise take the next write or enter the wait phase.
- Polling wait:
  - RD_ADDR reads 0x00.
  - RD_RESP has `rready` high.
  - If `rresp`!=0, set code 2 and go to FINISH.
  - If `rdata[1]` (`ap_done`) is set, go to FINISH.
  - Otherwise go to POLL_WAIT for POLL_GAP cycles, then back to RD_ADDR.
- Exactly one AXI transaction is outstanding at any time; reads and writes never overlap.
- Timeout counter:
  - Starts on the CTRL-write B handshake.
  - When it reaches TIMEOUT_CYCLES in POLL_WAIT or IRQ_WAIT, set code 3 and go to FINISH.
  - An in-flight transaction is always completed first.
- FINISH: one cycle. Pulses `done_o` (and `err_o` if code!=0), clears `busy_o`, returns to IDLE.
- An arg word is never skipped. NUM_ARGS=0 is legal: the sequence goes straight to the GIE/IER/CTRL writes.

## Timing
- Reset values: all valid/ready outputs 0; `busy_o`=0; `done_o`=0; `err_o`=0; `err_code_o`=0; address and data outputs 0; state IDLE.
- Reset mid-operation aborts immediately and drops all valids. The kernel is not stopped.
- `busy_o` rises the cycle after `launch_i` is sampled high.
- AW/W valid rises in that same cycle.
- Write cost:
  - Minimum 2 cycles per write with ready tied high and `bvalid` one cycle after the handshake.
  - Stalls on any channel extend it without losing data.
  - AW/W valid, address and data stay stable until their handshake.
- Read cost: minimum 2 cycles (AR, then R).
- `done_o` rises the cycle after the final qualifying response or event.
- `launch_i` in the same cycle as FINISH is ignored.
- Timeout counter is 32 bits wide and saturates.

## Configuration
- Macro: `HLS_CTRL_LAUNCHER_IRQ_EN`.
- Defined:
  - GIE/IER writes are inserted before the CTRL write.
  - After the CTRL write, go to IRQ_WAIT until `interrupt_i` is sampled high.
  - Then write ISR (0x0C) ← 1 (toggle-to-clear), then go to FINISH.
  - An ISR write error gives code 1.
  - No status reads are issued.
- Undefined:
  - Polling via 0x00 as described in Operation.
  - `interrupt_i` is unused.
  - The GIE/IER/ISR writes are absent.

## Test plan
- Polling build, NUM_ARGS=3, all readys high, args {64'h1_0000_1000, 64'h2000, 64'h3000}:
  - Exactly 7 writes: 0x10=1000, 0x14=1, 0x1C=2000, 0x20=0, 0x28=3000, 0x2C=0, 0x00=1.
  - Then reads of 0x00 until `rdata`=0x6; `done_o`=1 with `err_o`=0.
- AW and W readys delayed by random 0–5 cycles, independently: same write order, no duplicated or lost transaction, payload stable while valid.
- Slave returns `bresp`=2'b10 on the third write: sequence stops; `done_o`=1, `err_o`=1, `err_code_o`=1; no CTRL write issued.
- TIMEOUT_CYCLES=100, `ap_done` never set: `done_o`/`err_o` pulse with `err_code_o`=3 no later than ~100+POLL_GAP+read-latency cycles after the CTRL B handshake.
- IRQ build: `interrupt_i` raised 50 cycles after start:
  - Writes GIE=1, IER=1, CTRL=1, then ISR=1.
  - Zero reads issued.
  - `done_o` one cycle after the ISR B handshake.
- `rst_i` asserted during WR_RESP:
  - All valids are 0 in the same cycle (asynchronous).
  - After release, a new launch restarts from arg 0 low word.
